ysyx_22040750_fetch_pc_sequencer: RTL

Fetch-address sequencer in front of the IF stage. It owns the architectural fetch PC, advances it sequentially on each accepted fetch, and arbitrates two redirect requesters: the trap/CSR unit (mtvec/mepc) and the ID-stage jump/branch resolver. It holds a redirect target until IF accepts it and emits a one-cycle IF/ID flush on every taken redirect.

---
 rtl/ysyx_22040750_fetch_pc_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/ysyx_22040750_fetch_pc_sequencer.sv
// Fetch-address sequencer: owns the fetch PC, steps it on accepted fetches and
// arbitrates trap and branch redirects, holding a target until IF accepts it.
module ysyx_22040750_fetch_pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_trap_valid,
   input  logic [31:0] I_trap_pc,
   input  logic        I_br_valid,
   input  logic [31:0] I_br_pc,
   input  logic        I_stall,
   input  logic        I_if_ready,
   output logic        O_pc_valid,
   output logic [31:0] O_pc,
   output logic        O_flush,
   output logic [1:0]  O_redirect_src,
   output logic        O_busy
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

   localparam logic [1:0] SRC_NONE   = 2'b00;
   localparam logic [1:0] SRC_BRANCH = 2'b01;
   localparam logic [1:0] SRC_TRAP   = 2'b10;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        flush_q, flush_d;
   logic [1:0]  src_q, src_d;

   logic        hs;
   logic [31:0] br_target;
   logic [31:0] pc_plus4;

   // Stall only gates sequential issue; a held redirect target is always offered.
   assign O_pc_valid = (state_q != ST_BOOT) && (!I_stall || (state_q == ST_HOLD));
   assign hs         = O_pc_valid && I_if_ready;
   assign br_target  = I_br_pc & ~32'h0000_0001;
   assign pc_plus4   = pc_q + 32'd4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      src_d   = src_q;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
            src_d   = SRC_NONE;
         end
         ST_RUN: begin
            // A handshake coinciding with a redirect is wrong-path and is dropped.
            if (I_trap_valid) begin
               state_d = ST_HOLD;
               pc_d    = I_trap_pc;
               src_d   = SRC_TRAP;
               flush_d = 1'b1;
            end else if (I_br_valid) begin
               state_d = ST_HOLD;
               pc_d    = br_target;
               src_d   = SRC_BRANCH;
               flush_d = 1'b1;
            end else if (hs) begin
               pc_d    = pc_plus4;
            end
         end
         ST_HOLD: begin
            // Branches seen while holding come from the wrong path; only a trap may override.
            if (I_trap_valid) begin
               pc_d    = I_trap_pc;
               src_d   = SRC_TRAP;
               flush_d = 1'b1;
            end else if (hs) begin
               state_d = ST_RUN;
               pc_d    = pc_plus4;
               src_d   = SRC_NONE;
            end
         end
         default: begin
            state_d = ST_BOOT;
            pc_d    = RESET_PC;
            src_d   = SRC_NONE;
         end
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         flush_q <= 1'b0;
         src_q   <= SRC_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
         src_q   <= src_d;
      end
   end

   assign O_pc           = pc_q;
   assign O_flush        = flush_q;
   assign O_redirect_src = src_q;
   assign O_busy         = (state_q == ST_HOLD);

endmodule
